load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter n, default 64, meaning the data and address width in bits.
REQ-002 The block SHALL have parameter log2Size, default 10, meaning log2 of the memory depth in n-bit words.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit; reset SHALL be synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, 1 bit: a request is offered.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the unit accepts a request this cycle.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_size, input, 2 bits: 00 byte, 01 half, 10 word(32), 11 doubleword(64).
REQ-009 The block SHALL have port req_signed, input, 1 bit: sign-extend load data when 1.
REQ-010 The block SHALL have ports req_addr and req_wdata, input, n bits each: byte address and store data (right-aligned).
REQ-011 The block SHALL have port resp_valid, output, 1 bit; port resp_ready, input, 1 bit.
REQ-012 The block SHALL have ports resp_data, output, n bits, and resp_err, output, 1 bit.
REQ-013 The block SHALL have ports mem_addr and mem_wdata, output, n bits each, plus mem_read and mem_wr, output, 1 bit each, driving the word memory.
REQ-014 The block SHALL have port mem_rdata, input, n bits, the memory's combinational read data.

Function
REQ-015 States SHALL be IDLE, ACCESS, MERGE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 A request SHALL be accepted when req_valid and req_ready are both 1; all req_* fields SHALL be registered on acceptance.
REQ-017 mem_addr SHALL equal the zero-extended word index addr[log2Size+2:3]; byte offset SHALL be addr[2:0]; higher address bits SHALL be ignored.
REQ-018 IDLE SHALL go to ACCESS on acceptance, otherwise stay in IDLE.
REQ-019 In ACCESS for a load: mem_read=1, the addressed lane SHALL be extracted at offset*8 bits, zero- or sign-extended to n bits, registered into resp_data; next state RESP.
REQ-020 In ACCESS for a doubleword store: mem_wr=1, mem_wdata=req_wdata; next state RESP.
REQ-021 In ACCESS for a sub-word store: mem_read=1, the read word SHALL be captured; next state MERGE.
REQ-022 In MERGE: mem_wr=1, mem_wdata SHALL be the captured word with only the addressed lane replaced by the low bytes of req_wdata; next state RESP.
REQ-023 In RESP: resp_valid=1, held with resp_data/resp_err stable until resp_ready=1, then IDLE; resp_data SHALL be 0 for stores.
REQ-024 Latency from acceptance edge to resp_valid: load 2 cycles, doubleword store 2, sub-word store 3.
REQ-025 mem_read and mem_wr SHALL never be 1 together, SHALL be 0 outside ACCESS/MERGE, and mem_rdata SHALL be sampled only while mem_read=1.
REQ-026 Misaligned means addr[0]!=0 for half, addr[1:0]!=0 for word, addr[2:0]!=0 for doubleword; byte is never misaligned.

Reset
REQ-027 While rst=1, mem_read and mem_wr SHALL be forced 0 combinationally, so no write occurs at the reset edge.
REQ-028 After a reset edge: state IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_err=0, mem_addr=0, mem_wdata=0; an in-flight request SHALL be discarded without a response.

Configuration
REQ-029 With LSU_MISALIGN_TRAP_EN defined, a misaligned request SHALL skip ACCESS/MERGE, perform no memory access, and go IDLE->RESP with resp_err=1, resp_data=0.
REQ-030 Without LSU_MISALIGN_TRAP_EN, offset bits SHALL be aligned down to the access size, the access SHALL proceed normally, and resp_err SHALL remain 0.

Verification
REQ-031 Store D 0x1122334455667788 to addr 0x10, then load D -> mem word 2 written at cycle 1, load returns 0x1122334455667788, resp_valid 2 cycles after accept.
REQ-032 Store B 0xAB to addr 0x13 over word 0x1122334455667788 -> word becomes 0x11223344AB667788 via ACCESS read then MERGE write, resp 3 cycles after accept.
REQ-033 Load B addr 0x13 with req_signed=1 -> 0xFFFFFFFFFFFFFFAB; with req_signed=0 -> 0x00000000000000AB.
REQ-034 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_data stable, req_ready=0 throughout, no memory strobes.
REQ-035 Load W addr 0x12: with LSU_MISALIGN_TRAP_EN -> resp_err=1, mem_read never asserted; without -> reads lane at 0x10, resp_err=0.
REQ-036 Assert rst during MERGE of a sub-word store -> mem_wr=0 that cycle, memory word unchanged, next cycle IDLE with all outputs at reset values.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word/doubleword load-store engine in front of a single-port word memory.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake (ready only in IDLE)
//   req_we                   1 = store, 0 = load
//   req_size                 00 byte, 01 half, 10 word, 11 doubleword
//   req_signed               sign-extend load data
//   req_addr, req_wdata      byte address, right-aligned store data
//   resp_valid / resp_ready  response handshake
//   resp_data, resp_err      load data (0 for stores), misalignment error
//   mem_addr, mem_wdata      word index and write data to the memory
//   mem_read, mem_wr         memory strobes (never both, forced low in reset)
//   mem_rdata                combinational memory read data
//
// Build option: define LSU_MISALIGN_TRAP_EN to answer misaligned requests with
// resp_err=1 and no memory access; otherwise the offset is aligned down.
module load_store_unit #(
  parameter int n        = 64,
  parameter int log2Size = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [1:0]   req_size,
  input  logic         req_signed,
  input  logic [n-1:0] req_addr,
  input  logic [n-1:0] req_wdata,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [n-1:0] resp_data,
  output logic         resp_err,
  output logic [n-1:0] mem_addr,
  output logic [n-1:0] mem_wdata,
  output logic         mem_read,
  output logic         mem_wr,
  input  logic [n-1:0] mem_rdata
);
  localparam int AW = log2Size + 3;
  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;
  state_t        state_q, state_d;
  logic          we_q, we_d, signed_q, signed_d, err_q, err_d;
  logic [1:0]    size_q, size_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [n-1:0]  wdata_q, wdata_d, rdata_q, rdata_d, data_q, data_d;
  logic [2:0]    off;
  logic [5:0]    shamt;
  logic [n-1:0]  lane, lane_sh, rd_sh, load_ext, merged;
  logic          dword_st;
  logic          unused_addr;
  assign unused_addr = ^req_addr[n-1:AW];
  // Offset is aligned down to the access size; with the trap enabled a
  // misaligned request never reaches ACCESS, so this is harmless there.
  assign off = addr_q[2:0] & (size_q == 2'b00 ? 3'b111 : size_q == 2'b01 ? 3'b110 :
                              size_q == 2'b10 ? 3'b100 : 3'b000);
  assign shamt    = {off, 3'b000};
  assign lane     = size_q == 2'b00 ? n'(8'hFF) : size_q == 2'b01 ? n'(16'hFFFF) :
                    size_q == 2'b10 ? n'(32'hFFFF_FFFF) : '1;
  assign lane_sh  = lane << shamt;
  assign rd_sh    = mem_rdata >> shamt;
  assign load_ext = size_q == 2'b00 ? {{(n-8){signed_q & rd_sh[7]}}, rd_sh[7:0]} :
                    size_q == 2'b01 ? {{(n-16){signed_q & rd_sh[15]}}, rd_sh[15:0]} :
                    size_q == 2'b10 ? {{(n-32){signed_q & rd_sh[31]}}, rd_sh[31:0]} : rd_sh;
  assign merged   = (rdata_q & ~lane_sh) | ((wdata_q << shamt) & lane_sh);
  assign dword_st = we_q && size_q == 2'b11;
`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_req;
  assign mis_req = req_size == 2'b01 ? req_addr[0] : req_size == 2'b10 ? |req_addr[1:0] :
                   req_size == 2'b11 ? |req_addr[2:0] : 1'b0;
`endif
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    data_d   = data_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d     = req_we;
        size_d   = req_size;
        signed_d = req_signed;
        addr_d   = req_addr[AW-1:0];
        wdata_d  = req_wdata;
        data_d   = '0;
        err_d    = 1'b0;
        state_d  = ACCESS;
`ifdef LSU_MISALIGN_TRAP_EN
        if (mis_req) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
`endif
      end
      ACCESS: begin
        state_d = RESP;
        if (!we_q) data_d = load_ext;
        else if (!dword_st) begin
          rdata_d = mem_rdata;
          state_d = MERGE;
        end
      end
      MERGE:   state_d = RESP;
      default: if (resp_ready) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      size_q   <= '0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end
  assign req_ready  = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_data  = data_q;
  assign resp_err   = err_q;
  assign mem_addr   = {{(n-log2Size){1'b0}}, addr_q[AW-1:3]};
  assign mem_read   = !rst && state_q == ACCESS && !dword_st;
  assign mem_wr     = !rst && ((state_q == ACCESS && dword_st) || state_q == MERGE);
  assign mem_wdata  = state_q == MERGE ? merged : (state_q == ACCESS && dword_st) ? wdata_q : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit with a word-memory model.
module tb_load_store_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0, resp_ready = 1'b0;
  logic [1:0]  req_size = '0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_read, mem_wr;
  logic [63:0] resp_data, mem_addr, mem_wdata, mem_rdata;
  logic [63:0] mem [0:1023];
  int          errors = 0, checks = 0;

  load_store_unit #(.n(64), .log2Size(10)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[9:0]];
  always @(posedge clk) if (mem_wr) mem[mem_addr[9:0]] <= mem_wdata;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, follow it to RESP, hold resp_ready low for `hold` cycles, then retire it.
  task automatic xfer(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                      input logic [63:0] a, input logic [63:0] wd, input int hold,
                      input logic [63:0] exp_data, input logic exp_err, input int exp_lat,
                      input int exp_rd, input int exp_wr, input int exp_wr_at);
    int lat = 1, rd = 0, wr = 0, wr_at = 0, both = 0;
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    chk({tag, ".req_ready"}, req_ready, 1);
    tick;
    req_valid = 1'b0;
    while (!resp_valid && lat < 20) begin
      if (mem_read) rd++;
      if (mem_wr) begin wr++; wr_at = lat; end
      if (mem_read && mem_wr) both++;
      tick;
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".reads"}, 64'(rd), 64'(exp_rd));
    chk({tag, ".writes"}, 64'(wr), 64'(exp_wr));
    chk({tag, ".wr_cycle"}, 64'(wr_at), 64'(exp_wr_at));
    chk({tag, ".rd_wr_overlap"}, 64'(both), 0);
    chk({tag, ".data"}, resp_data, exp_data);
    chk({tag, ".err"}, resp_err, exp_err);
    for (int i = 0; i < hold; i++) begin
      tick;
      chk({tag, ".hold_valid"}, resp_valid, 1);
      chk({tag, ".hold_data"}, resp_data, exp_data);
      chk({tag, ".hold_ready"}, req_ready, 0);
      chk({tag, ".hold_strobes"}, {mem_read, mem_wr}, 0);
    end
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    chk({tag, ".back_idle"}, {req_ready, resp_valid}, 2'b10);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    tick;
    chk("rst.strobes", {mem_read, mem_wr}, 0);
    tick;
    rst = 1'b0;
    chk("rst.req_ready", req_ready, 1);
    chk("rst.resp_valid", resp_valid, 0);
    chk("rst.resp_data", resp_data, 0);
    chk("rst.resp_err", resp_err, 0);
    chk("rst.mem_addr", mem_addr, 0);
    chk("rst.mem_wdata", mem_wdata, 0);
    xfer("st_d", 1, 2'b11, 0, 64'h10, 64'h1122334455667788, 0, 0, 0, 2, 0, 1, 1);
    chk("st_d.mem2", mem[2], 64'h1122334455667788);
    xfer("ld_d", 0, 2'b11, 0, 64'h10, 0, 0, 64'h1122334455667788, 0, 2, 1, 0, 0);
    xfer("st_b", 1, 2'b00, 0, 64'h13, 64'hAB, 0, 0, 0, 3, 1, 1, 2);
    chk("st_b.mem2", mem[2], 64'h11223344AB667788);
    xfer("ld_b_s", 0, 2'b00, 1, 64'h13, 0, 0, 64'hFFFFFFFFFFFFFFAB, 0, 2, 1, 0, 0);
    xfer("ld_b_u", 0, 2'b00, 0, 64'h13, 0, 5, 64'h00000000000000AB, 0, 2, 1, 0, 0);
    xfer("st_h", 1, 2'b01, 0, 64'h16, 64'hFFFFBEEF, 0, 0, 0, 3, 1, 1, 2);
    chk("st_h.mem2", mem[2], 64'hBEEF3344AB667788);
    xfer("ld_h_s", 0, 2'b01, 1, 64'h16, 0, 0, 64'hFFFFFFFFFFFFBEEF, 0, 2, 1, 0, 0);
    xfer("ld_w_u", 0, 2'b10, 0, 64'h14, 0, 0, 64'h00000000BEEF3344, 0, 2, 1, 0, 0);
    xfer("ld_w_s", 0, 2'b10, 1, 64'h14, 0, 0, 64'hFFFFFFFFBEEF3344, 0, 2, 1, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    xfer("ld_w_mis", 0, 2'b10, 0, 64'h12, 0, 0, 0, 1, 1, 0, 0, 0);
`else
    xfer("ld_w_mis", 0, 2'b10, 0, 64'h12, 0, 0, 64'h00000000AB667788, 0, 2, 1, 0, 0);
`endif
    xfer("ld_hi_addr", 0, 2'b11, 0, 64'h2010, 0, 0, 64'hBEEF3344AB667788, 0, 2, 1, 0, 0);
    xfer("st_d5", 1, 2'b11, 0, 64'h28, 64'hCAFEF00D12345678, 0, 0, 0, 2, 0, 1, 1);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 64'h28; req_wdata = 64'h55;
    tick;
    req_valid = 1'b0;
    chk("rstm.access_read", mem_read, 1);
    tick;
    chk("rstm.merge_wr", mem_wr, 1);
    rst = 1'b1;
    #1;
    chk("rstm.wr_gated", mem_wr, 0);
    tick;
    rst = 1'b0;
    chk("rstm.mem5", mem[5], 64'hCAFEF00D12345678);
    chk("rstm.req_ready", req_ready, 1);
    chk("rstm.resp_valid", resp_valid, 0);
    chk("rstm.resp_data", resp_data, 0);
    chk("rstm.mem_addr", mem_addr, 0);
    chk("rstm.mem_wdata", mem_wdata, 0);
    tick;
    tick;
    chk("rstm.no_resp", resp_valid, 0);
    xfer("ld_b5", 0, 2'b00, 0, 64'h28, 0, 0, 64'h78, 0, 2, 1, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
